// File: rtl/forward_scoreboard_pkg.sv
// Shared CPU defines for the EXE-stage forwarding scoreboard: entry layout,
// the register-file select code and ready-stage normalisation.
package forward_scoreboard_pkg;

    // Wide enough for pipelines of up to 15 tracked post-EXE stages.
    localparam int FWD_RDY_W  = 4;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                 valid;
        logic [4:0]           dst;
        logic [FWD_RDY_W-1:0] rdy_stg;
    } fwd_entry_t;

    // A ready stage of 0 or beyond the last tracked stage means "last stage".
    function automatic logic [FWD_RDY_W-1:0] norm_rdy_stg(input int rdy, input int stages);
        if (rdy == 0 || rdy > stages) begin
            return FWD_RDY_W'(stages);
        end
        return FWD_RDY_W'(rdy);
    endfunction

endpackage

// File: rtl/forward_scoreboard_match.sv
// Resolves one EXE source against the in-flight producers: the youngest
// matching stage decides between a forward select and a hazard.
module fwd_match
    import forward_scoreboard_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int SEL_W  = $clog2(STAGES + 1)
) (
    input  fwd_entry_t [STAGES-1:0] entries,
    input  logic [4:0]              src_addr,
    input  logic                    src_used,
    output logic [SEL_W-1:0]        sel,
    output logic                    hazard
);

    logic found;

    always_comb begin
        sel    = SEL_W'(FWD_SEL_RF);
        hazard = 1'b0;
        found  = 1'b0;
        // $0 is never a real dependency, so it short-circuits the whole search.
        if (src_used && src_addr != 5'd0) begin
            for (int k = 1; k <= STAGES; k++) begin
                if (!found && entries[k-1].valid && entries[k-1].dst == src_addr) begin
                    found = 1'b1;
                    if (k >= int'(entries[k-1].rdy_stg)) begin
                        sel = SEL_W'(k);
                    end else begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// Tracks GPR producers in the post-EXE stages and picks forward sources for
// the EXE operands. Entries move one stage on each clk edge with pipe_adv=1.
module forward_scoreboard
    import forward_scoreboard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int STAGES  = 2,
    parameter int SEL_W   = $clog2(STAGES + 1)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          pipe_adv,
    input  logic                          iss_valid,
    input  logic                          iss_rfwr,
    input  logic [4:0]                    iss_dst,
    input  logic [SEL_W-1:0]              iss_rdy_stg,
    input  logic [STAGES-1:0]             flush_mask,
    input  logic [NUM_SRC-1:0][4:0]       src_addr,
    input  logic [NUM_SRC-1:0]            src_used,
    output logic [NUM_SRC-1:0][SEL_W-1:0] fwd_sel,
    output logic                          stall,
    output logic [31:0]                   stall_cnt
);

    fwd_entry_t [STAGES-1:0] ent;
    fwd_entry_t [STAGES-1:0] ent_nxt;
    logic [NUM_SRC-1:0]      hazard;

    always_comb begin
        ent_nxt = ent;
        if (pipe_adv) begin
            ent_nxt[0].valid   = iss_valid & iss_rfwr;
            ent_nxt[0].dst     = iss_dst;
            ent_nxt[0].rdy_stg = norm_rdy_stg(int'(iss_rdy_stg), STAGES);
            for (int k = 1; k < STAGES; k++) begin
                ent_nxt[k] = ent[k-1];
            end
        end
        // Flush is applied to the post-shift view, so it also kills a fresh load.
        for (int k = 0; k < STAGES; k++) begin
            if (flush_mask[k]) begin
                ent_nxt[k].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ent <= '0;
        end else begin
            ent <= ent_nxt;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_match #(
            .STAGES (STAGES),
            .SEL_W  (SEL_W)
        ) u_match (
            .entries  (ent),
            .src_addr (src_addr[i]),
            .src_used (src_used[i]),
            .sel      (fwd_sel[i]),
            .hazard   (hazard[i])
        );
    end

    assign stall = |hazard;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= 32'd0;
        end else if (stall && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Bench for forward_scoreboard: directed scenarios plus randomized traffic
// compared against a queue-based model of the in-flight producers.
module tb_forward_scoreboard;

    localparam int NUM_SRC = 2;
    localparam int STAGES  = 2;
    localparam int SEL_W   = 2;

    logic                          clk;
    logic                          resetn;
    logic                          pipe_adv;
    logic                          iss_valid;
    logic                          iss_rfwr;
    logic [4:0]                    iss_dst;
    logic [SEL_W-1:0]              iss_rdy_stg;
    logic [STAGES-1:0]             flush_mask;
    logic [NUM_SRC-1:0][4:0]       src_addr;
    logic [NUM_SRC-1:0]            src_used;
    logic [NUM_SRC-1:0][SEL_W-1:0] fwd_sel;
    logic                          stall;
    logic [31:0]                   stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    forward_scoreboard #(
        .NUM_SRC (NUM_SRC),
        .STAGES  (STAGES),
        .SEL_W   (SEL_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pipe_adv    (pipe_adv),
        .iss_valid   (iss_valid),
        .iss_rfwr    (iss_rfwr),
        .iss_dst     (iss_dst),
        .iss_rdy_stg (iss_rdy_stg),
        .flush_mask  (flush_mask),
        .src_addr    (src_addr),
        .src_used    (src_used),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: list of in-flight producers, youngest first
    typedef struct {
        bit v;
        int dst;
        int rdy;
    } rec_t;

    rec_t        pipe_q[$];
    logic [31:0] mcnt;

    function automatic void model_lookup(input int i, output int sel, output bit hz);
        sel = 0;
        hz  = 1'b0;
        if (src_used[i] && src_addr[i] != 5'd0) begin
            for (int k = 0; k < pipe_q.size(); k++) begin
                if (pipe_q[k].v && pipe_q[k].dst == int'(src_addr[i])) begin
                    if (k + 1 >= pipe_q[k].rdy) sel = k + 1;
                    else hz = 1'b1;
                    break;
                end
            end
        end
    endfunction

    function automatic bit model_stall();
        int s;
        bit h;
        bit any = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            model_lookup(i, s, h);
            any |= h;
        end
        return any;
    endfunction

    initial begin
        int r;
        for (int k = 0; k < STAGES; k++) pipe_q.push_back('{1'b0, 0, 0});
        mcnt = 32'd0;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                for (int k = 0; k < STAGES; k++) pipe_q[k].v = 1'b0;
                mcnt = 32'd0;
            end else begin
                if (model_stall() && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
                if (pipe_adv) begin
                    r = int'(iss_rdy_stg);
                    if (r == 0 || r > STAGES) r = STAGES;
                    pipe_q.push_front('{bit'(iss_valid && iss_rfwr), int'(iss_dst), r});
                    void'(pipe_q.pop_back());
                end
                for (int k = 0; k < STAGES; k++) begin
                    if (flush_mask[k]) pipe_q[k].v = 1'b0;
                end
            end
        end
    end

    // driver tasks
    task automatic drive(input logic adv, input logic v, input logic wr, input logic [4:0] dst,
                         input logic [1:0] rdy, input logic [1:0] fl, input logic [4:0] s0,
                         input logic [4:0] s1, input logic [1:0] used);
        @(negedge clk);
        pipe_adv    = adv;
        iss_valid   = v;
        iss_rfwr    = wr;
        iss_dst     = dst;
        iss_rdy_stg = rdy;
        flush_mask  = fl;
        src_addr[0] = s0;
        src_addr[1] = s1;
        src_used    = used;
        #1;
    endtask

    task automatic drain();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b00);
        n_checks++;
        if (fwd_sel !== '0 || stall !== 1'b0 || stall_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL reset: fwd_sel=%h stall=%b stall_cnt=%0d, want 0/0/0", fwd_sel, stall, stall_cnt);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_load_use();
        drain();
        drive(1'b1, 1'b1, 1'b1, 5'd8, 2'd2, 2'b00, 5'd0, 5'd0, 2'b00);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd0, 5'd8, 2'b10);
        n_checks++;
        if (stall !== 1'b1 || fwd_sel[1] !== 2'd0 || stall_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL load_use_stall: stall=%b sel1=%0d cnt=%0d, want 1/0/0", stall, fwd_sel[1], stall_cnt);
        end
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd0, 5'd8, 2'b10);
        n_checks++;
        if (stall !== 1'b0 || fwd_sel[1] !== 2'd2 || stall_cnt !== 32'd1) begin
            n_errors++;
            $display("FAIL load_use_fwd: stall=%b sel1=%0d cnt=%0d, want 0/2/1", stall, fwd_sel[1], stall_cnt);
        end
    endtask

    task automatic test_alu_back_to_back();
        drain();
        drive(1'b1, 1'b1, 1'b1, 5'd5, 2'd1, 2'b00, 5'd0, 5'd0, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd5, 5'd0, 2'b01);
        n_checks++;
        if (fwd_sel[0] !== 2'd1 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL alu_stage1: sel0=%0d stall=%b, want 1/0", fwd_sel[0], stall);
        end
        drive(1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd5, 5'd0, 2'b01);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd5, 5'd0, 2'b01);
        n_checks++;
        if (fwd_sel[0] !== 2'd2 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL alu_stage2: sel0=%0d stall=%b, want 2/0", fwd_sel[0], stall);
        end
    endtask

    task automatic test_youngest_wins();
        drain();
        drive(1'b1, 1'b1, 1'b1, 5'd3, 2'd1, 2'b00, 5'd0, 5'd0, 2'b00);
        drive(1'b1, 1'b1, 1'b1, 5'd3, 2'd1, 2'b00, 5'd0, 5'd0, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd3, 5'd3, 2'b11);
        n_checks++;
        if (fwd_sel[0] !== 2'd1 || fwd_sel[1] !== 2'd1 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL youngest_ready: sel=%h stall=%b, want 5/0", fwd_sel, stall);
        end
        // a not-ready youngest producer must stall even though stage 2 is ready
        drive(1'b1, 1'b1, 1'b1, 5'd3, 2'd2, 2'b00, 5'd0, 5'd0, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd3, 5'd0, 2'b01);
        n_checks++;
        if (fwd_sel[0] !== 2'd0 || stall !== 1'b1) begin
            n_errors++;
            $display("FAIL youngest_not_ready: sel0=%0d stall=%b, want 0/1", fwd_sel[0], stall);
        end
    endtask

    task automatic test_zero_unused();
        drain();
        drive(1'b1, 1'b1, 1'b1, 5'd0, 2'd1, 2'b00, 5'd0, 5'd0, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd0, 5'd0, 2'b11);
        n_checks++;
        if (fwd_sel !== '0 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_reg: sel=%h stall=%b, want 0/0", fwd_sel, stall);
        end
        drive(1'b1, 1'b1, 1'b1, 5'd7, 2'd2, 2'b00, 5'd0, 5'd0, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd7, 5'd7, 2'b00);
        n_checks++;
        if (fwd_sel !== '0 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL unused_src: sel=%h stall=%b, want 0/0", fwd_sel, stall);
        end
    endtask

    task automatic test_flush();
        drain();
        drive(1'b1, 1'b1, 1'b1, 5'd9, 2'd1, 2'b00, 5'd0, 5'd0, 2'b00);
        drive(1'b1, 1'b1, 1'b1, 5'd10, 2'd1, 2'b01, 5'd0, 5'd0, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd9, 5'd10, 2'b11);
        n_checks++;
        if (fwd_sel[0] !== 2'd2 || fwd_sel[1] !== 2'd0 || stall !== 1'b0) begin
            n_errors++;
            $display("FAIL flush: sel0=%0d sel1=%0d stall=%b, want 2/0/0", fwd_sel[0], fwd_sel[1], stall);
        end
    endtask

    task automatic test_reset_mid_stall();
        drain();
        drive(1'b1, 1'b1, 1'b1, 5'd12, 2'd2, 2'b00, 5'd0, 5'd0, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 2'b00, 5'd12, 5'd0, 2'b01);
        n_checks++;
        if (stall !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset_stall: stall=%b, want 1", stall);
        end
        #1 resetn = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0 || stall_cnt !== 32'd0 || fwd_sel !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_stall: stall=%b cnt=%0d sel=%h, want 0/0/0", stall, stall_cnt, fwd_sel);
        end
        drive(1'b1, 1'b1, 1'b1, 5'd12, 2'd2, 2'b00, 5'd12, 5'd0, 2'b01);
        n_checks++;
        if (stall !== 1'b0 || stall_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_hold: stall=%b cnt=%0d, want 0/0", stall, stall_cnt);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_random();
        logic [4:0] exp_q[$];
        logic [4:0] got;
        logic [4:0] want;
        int         s0, s1;
        bit         h0, h1, st;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            src_addr[0] = 5'($urandom_range(0, 7));
            src_addr[1] = 5'($urandom_range(0, 7));
            src_used    = 2'($urandom_range(0, 3));
            st          = model_stall();
            pipe_adv    = ($urandom_range(0, 3) != 0);
            iss_valid   = st ? 1'b0 : 1'($urandom_range(0, 1));
            iss_rfwr    = ($urandom_range(0, 3) != 0);
            iss_dst     = 5'($urandom_range(0, 7));
            iss_rdy_stg = 2'($urandom_range(0, 3));
            flush_mask  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            model_lookup(0, s0, h0);
            model_lookup(1, s1, h1);
            exp_q.push_back({st, 2'(s1), 2'(s0)});
            #1;
            want = exp_q.pop_front();
            got  = {stall, fwd_sel[1], fwd_sel[0]};
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL random_out cyc %0d: {stall,sel1,sel0}=%b, want %b", c, got, want);
            end
            n_checks++;
            if (stall_cnt !== mcnt) begin
                n_errors++;
                $display("FAIL random_cnt cyc %0d: stall_cnt=%0d, want %0d", c, stall_cnt, mcnt);
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        test_reset();
        test_load_use();
        test_alu_back_to_back();
        test_youngest_wins();
        test_zero_unused();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
